// File: rtl/rv32i_imem_loader.sv
// Instruction memory loader for the rv32i core: assembles a little-endian byte
// stream into words, then serves registered instruction fetches with status flags.
module rv32i_imem_loader #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ld_valid_i,
  input  logic [7:0]                   ld_data_i,
  input  logic                         ld_last_i,
  output logic                         ld_ready_o,
  output logic                         core_hold_o,
  input  logic                         fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]        instrAddr_i,
  output logic [31:0]                  instruction_o,
  output logic                         instr_valid_o,
  output logic                         prog_end_o,
  output logic                         misaligned_o,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH_WORDS):0] word_count_o
);

  localparam int MAW = $clog2(DEPTH_WORDS);
  localparam int CW  = MAW + 1;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   asm_q, asm_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic [31:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          prog_end_q, prog_end_d;
  logic          misaligned_q, misaligned_d;
  logic          overflow_q, overflow_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          full;
  logic          ld_ready;
  logic          mem_we;
  logic [31:0]   word_new;
  logic [31:0]   fetch_idx;
  logic [31:0]   fetch_word;

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    word_count_d  = word_count_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    prog_end_d    = prog_end_q;
    misaligned_d  = misaligned_q;
    overflow_d    = overflow_q;
    mem_we        = 1'b0;
    ld_ready      = 1'b0;
    full          = (word_count_q == CW'(DEPTH_WORDS));
    // Upper lanes of the assembly register are still zero, so a short final word needs no masking.
    word_new      = asm_q;
    word_new[8*byte_idx_q +: 8] = ld_data_i;
    fetch_idx     = 32'(instrAddr_i >> 2);
    fetch_word    = mem[fetch_idx[MAW-1:0]];

    case (state_q)
      ST_LOAD: begin
        ld_ready = !full;
        if (ld_valid_i && !full) begin
          asm_d      = word_new;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3 || ld_last_i) begin
            mem_we       = 1'b1;
            word_count_d = word_count_q + CW'(1);
            asm_d        = '0;
            byte_idx_d   = 2'd0;
            if (ld_last_i) begin
              state_d = ST_RUN;
            end else if (word_count_q == CW'(DEPTH_WORDS - 1)) begin
              state_d    = ST_RUN;
              overflow_d = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (fetch_req_i) begin
          instr_valid_d = 1'b1;
          if (instrAddr_i[1:0] != 2'b00) begin
            instr_d      = NOP_WORD;
            misaligned_d = 1'b1;
            prog_end_d   = 1'b0;
          end else if (fetch_idx >= 32'(word_count_q)) begin
            instr_d    = NOP_WORD;
            prog_end_d = 1'b1;
          end else begin
            instr_d    = fetch_word;
            prog_end_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_LOAD;
      byte_idx_q    <= 2'd0;
      asm_q         <= '0;
      word_count_q  <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      prog_end_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      word_count_q  <= word_count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      prog_end_q    <= prog_end_d;
      misaligned_q  <= misaligned_d;
      overflow_q    <= overflow_d;
    end
  end

  // Memory is deliberately not reset; word_count gates every read.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[word_count_q[MAW-1:0]] <= word_new;
    end
  end

  assign ld_ready_o    = ld_ready;
  assign core_hold_o   = (state_q == ST_LOAD);
  assign instruction_o = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign prog_end_o    = prog_end_q;
  assign misaligned_o  = misaligned_q;
  assign overflow_o    = overflow_q;
  assign word_count_o  = word_count_q;

endmodule

// File: doc/rv32i_imem_loader.md
Name: rv32i_imem_loader

Overview:
- Instruction-side partner of the rv32i core: receives a program as a little-endian byte stream and writes it into word memory.
- After loading, answers the core's instruction fetches with a registered 32-bit word and validity/status flags.
- Holds the core while loading and signals end-of-program explicitly, so benches stop on prog_end rather than on X instructions.

Parameters:
ADDR_WIDTH, 16, width of byte fetch address (matches core instrAddr)
DEPTH_WORDS, 256, instruction words stored (power of two, 4..16384)
NOP_WORD, 32'h00000013, word returned for any invalid fetch (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ld_valid  input  1  load byte present
ld_data  input  8  load byte, program order, little-endian within each word
ld_last  input  1  marks final byte of program; qualified by ld_valid
ld_ready  output  1  byte accepted on cycles where ld_valid && ld_ready
core_hold  output  1  high while loading; core must not fetch/advance
fetch_req  input  1  fetch strobe from core
instrAddr  input  ADDR_WIDTH  byte address of fetch
instruction  output  32  fetched word, registered
instr_valid  output  1  instruction valid, one cycle after accepted fetch_req
prog_end  output  1  registered with instruction: fetch at/after end of loaded program
misaligned  output  1  sticky: a fetch with instrAddr[1:0] != 0 occurred in RUN
overflow  output  1  sticky: load stopped because DEPTH_WORDS words were filled
word_count  output  log2(DEPTH_WORDS)+1  number of words loaded

Behaviour:
- Reset values: state=LOAD, ld_ready=1, core_hold=1, instruction=NOP_WORD, instr_valid=0, prog_end=0, misaligned=0, overflow=0, word_count=0, byte_idx=0, assembly register=0. Memory array is not cleared.
- FSM states: LOAD and RUN only. No return from RUN except via rst.
- LOAD:
  - ld_ready = !full, where full = (word_count == DEPTH_WORDS).
  - Accepted byte goes to lane byte_idx of the assembly word (lane 0 = bits 7:0); byte_idx increments mod 4.
  - When the lane-3 byte is accepted, the completed word is written to mem[word_count], word_count increments, and the assembly register clears.
  - ld_last with byte_idx != 3: word is still written, unfilled upper lanes forced to 0, word_count increments.
  - Any accepted ld_last: next state RUN, byte_idx=0.
  - Completing word DEPTH_WORDS without ld_last: next state RUN, overflow=1, ld_ready=0. Later bytes are ignored.
  - ld_last on an empty program is impossible, since ld_last always carries a byte (minimum word_count=1).
- RUN:
  - ld_ready=0, core_hold=0.
  - fetch_req in cycle N produces, in cycle N+1: instr_valid=1 plus instruction/prog_end as below.
  - instrAddr[1:0] != 0: instruction=NOP_WORD, misaligned set (sticky), prog_end=0.
  - Word index idx = instrAddr >> 2, compared at full width.
  - idx >= word_count: instruction=NOP_WORD, prog_end=1.
  - Otherwise: instruction=mem[idx], prog_end=0.
  - No fetch_req in cycle N: instr_valid=0 in N+1. instruction holds its last value; prog_end holds.
  - Back-to-back fetches every cycle are supported, throughput 1 per cycle.
- fetch_req during LOAD is ignored: instr_valid stays 0, no flags change.
- rst mid-load or mid-run: all registers return to reset values next edge. Stale memory is unreachable because word_count=0.
- Simultaneous ld_valid and fetch_req in LOAD: only the load is processed.

Test Plan:
- Load bytes 13 00 00 00 93 00 50 00 (ld_last on 8th) -> word_count=2, RUN, core_hold=0. Fetch 0x0000 -> next cycle instruction=0x00000013, instr_valid=1. Fetch 0x0004 -> 0x00500093. Fetch 0x0008 -> NOP_WORD, prog_end=1.
- Load 5 bytes 11 22 33 44 BB with ld_last on BB -> word_count=2, mem[1]=0x000000BB. Fetch 0x0004 returns 0x000000BB.
- After the first load, fetch 0x0002 -> instruction=0x00000013 (NOP), misaligned=1 and stays 1 after a later aligned fetch of 0x0000.
- DEPTH_WORDS=4: stream 16 bytes without ld_last -> after 16th byte state RUN, overflow=1, ld_ready=0, word_count=4. A 17th ld_valid is not accepted.
- Assert rst after 3 bytes accepted -> next cycle word_count=0, ld_ready=1, core_hold=1. Reload 4 bytes EF BE AD DE with last -> fetch 0x0000 returns 0xDEADBEEF.
- Pulse fetch_req during LOAD -> instr_valid stays 0. Fetch every cycle for addresses 0, 4, 8 in RUN -> three consecutive instr_valid pulses with correct data, prog_end only on the third.
